// File: rtl/demux_1to16_deser_pkg.sv
// Shared defaults, FSM state type and constants for the 1:16 bit deserialiser.
`timescale 1ns/1ps
package demux_deser_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SEL_W = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        PEND    = 1'b1
    } state_e;

    localparam logic [DEF_WIDTH-1:0] MASK_FULL = '1;

endpackage

// File: rtl/demux_1to16_deser_if.sv
// Serial-bit input, word output and status bundle of the deserialiser.
`timescale 1ns/1ps
interface demux_1to16_deser_if
    import demux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEL_W = DEF_SEL_W
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             addr_mode;
    logic [SEL_W-1:0] select;
    logic             flush;
    logic [WIDTH-1:0] data_out;
    logic             word_valid;
    logic             word_partial;
    logic             word_ready;
    logic [SEL_W:0]   fill_count;

    // Deserialiser side
    modport slave (
        input  bit_in, bit_valid, addr_mode, select, flush, word_ready,
        output bit_ready, data_out, word_valid, word_partial, fill_count
    );

    // Bit producer / word consumer side
    modport master (
        output bit_in, bit_valid, addr_mode, select, flush, word_ready,
        input  bit_ready, data_out, word_valid, word_partial, fill_count
    );
endinterface

// File: rtl/demux_1to16_deser_out_reg.sv
// One-word valid/ready holding register for assembled words.
`timescale 1ns/1ps
module demux_out_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_partial,
    input  logic             word_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             word_valid,
    output logic             word_partial
);

    // A new load takes priority over a pop; data stays stable while unaccepted
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out     <= '0;
            word_valid   <= 1'b0;
            word_partial <= 1'b0;
        end else if (load) begin
            data_out     <= load_data;
            word_valid   <= 1'b1;
            word_partial <= load_partial;
        end else if (word_valid && word_ready) begin
            word_valid   <= 1'b0;
            word_partial <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to16_deser.sv
// 1:16 deserialiser: steers one bit per handshake into a word slot chosen by
// select or an auto-increment pointer, and emits completed or flushed words.
`timescale 1ns/1ps
module demux_1to16_deser
    import demux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    demux_1to16_deser_if.slave  bus
);

    localparam int unsigned CNT_W = SEL_W + 1;

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] collect;
    logic [WIDTH-1:0] mask;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] fill_q;
    logic             bit_ready_q;

    logic             accept;
    logic [SEL_W-1:0] slot;
    logic [WIDTH-1:0] collect_acc;
    logic [WIDTH-1:0] mask_acc;
    logic             out_free;
    logic             complete;

    logic             load;
    logic             load_partial;
    logic [WIDTH-1:0] load_data;
    logic             clear;

    logic [WIDTH-1:0] collect_next;
    logic [WIDTH-1:0] mask_next;
    logic [SEL_W-1:0] ptr_next;
    logic [CNT_W-1:0] fill_next;

    // Accepted bit merged into the working word and mask
    always_comb begin
        accept      = bus.bit_valid && bit_ready_q;
        slot        = bus.addr_mode ? bus.select : ptr;
        collect_acc = collect;
        mask_acc    = mask;
        if (accept) begin
            collect_acc[slot] = bus.bit_in;
            mask_acc[slot]    = 1'b1;
        end
        out_free = !bus.word_valid || bus.word_ready;
        complete = accept && (&mask_acc);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: park a full word in PEND while the output is occupied
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (complete && !out_free) state_next = PEND;
            PEND:    if (bus.word_ready)        state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // FSM outputs: output-register load and working-word clear strobes
    always_comb begin
        load         = 1'b0;
        load_partial = 1'b0;
        load_data    = collect_acc;
        clear        = 1'b0;
        case (state)
            COLLECT: begin
                if (complete) begin
                    if (out_free) begin
                        load  = 1'b1;
                        clear = 1'b1;
                    end
                end else if (bus.flush && (|mask_acc) && out_free) begin
                    load         = 1'b1;
                    load_partial = 1'b1;
                    clear        = 1'b1;
                end
            end
            PEND: begin
                load_data = collect;
                if (bus.word_ready) begin
                    load  = 1'b1;
                    clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next working word, pointer and fill count
    always_comb begin
        collect_next = collect_acc;
        mask_next    = mask_acc;
        ptr_next     = ptr;
        if (accept && !bus.addr_mode) begin
            ptr_next = SEL_W'(ptr + 1'b1);
        end
        if (clear) begin
            collect_next = '0;
            mask_next    = '0;
            ptr_next     = '0;
        end
        fill_next = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            fill_next = fill_next + CNT_W'(mask_next[i]);
        end
    end

    // Working word registers; bit_ready tracks the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            collect     <= '0;
            mask        <= '0;
            ptr         <= '0;
            fill_q      <= '0;
            bit_ready_q <= 1'b1;
        end else begin
            collect     <= collect_next;
            mask        <= mask_next;
            ptr         <= ptr_next;
            fill_q      <= fill_next;
            bit_ready_q <= (state_next == COLLECT);
        end
    end

    assign bus.bit_ready  = bit_ready_q;
    assign bus.fill_count = fill_q;

    demux_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .load_data    (load_data),
        .load_partial (load_partial),
        .word_ready   (bus.word_ready),
        .data_out     (bus.data_out),
        .word_valid   (bus.word_valid),
        .word_partial (bus.word_partial)
    );

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Directed bench for the 1:16 deserialiser with immediate-assertion checks.
`timescale 1ns/1ps
module tb_demux_1to16_deser;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demux_1to16_deser_if bus ();

    demux_1to16_deser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.addr_mode  = 1'b0;
        bus.select     = '0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_data",    32'(bus.data_out),     32'h0);
        chk("rst_valid",   32'(bus.word_valid),   32'h0);
        chk("rst_partial", 32'(bus.word_partial), 32'h0);
        chk("rst_fill",    32'(bus.fill_count),   32'h0);
        chk("rst_ready",   32'(bus.bit_ready),    32'h1);

        // Auto mode word 0x0F0D, LSB first
        w = 16'h0F0D;
        for (int i = 0; i < 15; i++) send(w[i]);
        chk("auto_fill15",  32'(bus.fill_count), 32'd15);
        chk("auto_novalid", 32'(bus.word_valid), 32'h0);
        send(w[15]);
        chk("auto_valid",   32'(bus.word_valid),   32'h1);
        chk("auto_data",    32'(bus.data_out),     32'h0F0D);
        chk("auto_partial", 32'(bus.word_partial), 32'h0);
        chk("auto_fill0",   32'(bus.fill_count),   32'h0);
        tick();
        chk("auto_pop", 32'(bus.word_valid), 32'h0);

        // Addressed mode, reverse slot order
        bus.addr_mode = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            bus.select = 4'(i);
            send(1'b1);
        end
        chk("addr_valid", 32'(bus.word_valid), 32'h1);
        chk("addr_data",  32'(bus.data_out),   32'hFFFF);
        tick();
        chk("addr_pop", 32'(bus.word_valid), 32'h0);
        bus.select = 4'd3;
        send(1'b1);
        send(1'b0);
        chk("addr_overwrite_fill", 32'(bus.fill_count), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("addr_ovw_valid",   32'(bus.word_valid),   32'h1);
        chk("addr_ovw_data",    32'(bus.data_out),     32'h0000);
        chk("addr_ovw_partial", 32'(bus.word_partial), 32'h1);
        tick();
        chk("addr_ovw_pop", 32'(bus.word_valid), 32'h0);

        // Backpressure: 32 ones with the consumer stalled
        bus.addr_mode  = 1'b0;
        bus.word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b1);
        chk("bp_first_valid", 32'(bus.word_valid), 32'h1);
        chk("bp_first_data",  32'(bus.data_out),   32'hFFFF);
        chk("bp_ready_mid",   32'(bus.bit_ready),  32'h1);
        for (int i = 0; i < 16; i++) send(1'b1);
        chk("bp_pend_ready", 32'(bus.bit_ready),  32'h0);
        chk("bp_pend_valid", 32'(bus.word_valid), 32'h1);
        chk("bp_pend_fill",  32'(bus.fill_count), 32'd16);
        tick();
        chk("bp_pend_hold", 32'(bus.bit_ready), 32'h0);
        bus.word_ready = 1'b1;
        tick();
        chk("bp_xfer_valid", 32'(bus.word_valid),   32'h1);
        chk("bp_xfer_data",  32'(bus.data_out),     32'hFFFF);
        chk("bp_xfer_part",  32'(bus.word_partial), 32'h0);
        chk("bp_xfer_ready", 32'(bus.bit_ready),    32'h1);
        chk("bp_xfer_fill",  32'(bus.fill_count),   32'h0);
        tick();
        chk("bp_pop", 32'(bus.word_valid), 32'h0);

        // Flush of a three-bit partial word, then flush with nothing collected
        send(1'b1);
        send(1'b1);
        send(1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_valid",   32'(bus.word_valid),   32'h1);
        chk("flush_data",    32'(bus.data_out),     32'h0007);
        chk("flush_partial", 32'(bus.word_partial), 32'h1);
        tick();
        chk("flush_pop", 32'(bus.word_valid), 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_empty", 32'(bus.word_valid), 32'h0);

        // Reset mid-word, then a clean word
        for (int i = 0; i < 8; i++) send(1'b1);
        chk("mid_fill8", 32'(bus.fill_count), 32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_fill",  32'(bus.fill_count), 32'h0);
        chk("mid_rst_valid", 32'(bus.word_valid), 32'h0);
        chk("mid_rst_ready", 32'(bus.bit_ready),  32'h1);
        w = 16'h1234;
        for (int i = 0; i < 16; i++) send(w[i]);
        chk("mid_clean_valid", 32'(bus.word_valid), 32'h1);
        chk("mid_clean_data",  32'(bus.data_out),   32'h1234);
        tick();

        // Completion coinciding with word_ready while a word is held
        bus.word_ready = 1'b0;
        w = 16'hA5A5;
        for (int i = 0; i < 16; i++) send(w[i]);
        chk("cc_first_data", 32'(bus.data_out), 32'hA5A5);
        w = 16'h5A5A;
        for (int i = 0; i < 15; i++) send(w[i]);
        chk("cc_held_data",  32'(bus.data_out),   32'hA5A5);
        chk("cc_held_valid", 32'(bus.word_valid), 32'h1);
        chk("cc_fill15",     32'(bus.fill_count), 32'd15);
        bus.word_ready = 1'b1;
        send(w[15]);
        chk("cc_data",  32'(bus.data_out),   32'h5A5A);
        chk("cc_valid", 32'(bus.word_valid), 32'h1);
        chk("cc_ready", 32'(bus.bit_ready),  32'h1);
        chk("cc_fill",  32'(bus.fill_count), 32'h0);
        tick();
        chk("cc_pop", 32'(bus.word_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
